// File: rtl/pipe_stage_reg_pkg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg_pkg
// Shared pipeline definitions: default datapath/control/counter widths and the
// bit layout of the packed control vector carried between pipeline stages.
// Stages select control fields through these offsets and never redefine them.
// -----------------------------------------------------------------------------
package pipe_stage_reg_pkg;

    // Default widths
    localparam int PSR_DATA_W = 32;
    localparam int PSR_CTRL_W = 24;
    localparam int PSR_CNT_W  = 16;

    // Control vector field layout (LSB offsets and widths)
    localparam int PSR_ALUOP_LSB    = 0;
    localparam int PSR_ALUOP_W      = 4;
    localparam int PSR_REGWR_LSB    = 4;   // per-byte register write enables
    localparam int PSR_REGWR_W      = 4;
    localparam int PSR_MEMWR_BIT    = 8;
    localparam int PSR_MEMTOREG_BIT = 9;
    localparam int PSR_BRANCH_BIT   = 10;
    localparam int PSR_JUMP_BIT     = 11;
    localparam int PSR_SHAMT_LSB    = 12;
    localparam int PSR_SHAMT_W      = 5;
    localparam int PSR_SHTYPE_LSB   = 17;
    localparam int PSR_SHTYPE_W     = 2;

    // True when the control vector would cause any architectural write.
    function automatic logic ctrl_any_wr(input logic [PSR_CTRL_W-1:0] c);
        return (|c[PSR_REGWR_LSB +: PSR_REGWR_W]) | c[PSR_MEMWR_BIT];
    endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter, synchronous active-high clear.
// Ports:
//   clk  - clock
//   rst  - synchronous clear to 0
//   inc  - count enable; ignored once the counter is all ones
//   cnt  - current count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Two-entry (main + skid) valid/ready pipeline register with flush and a
// saturating stall counter. in_ready comes straight from the skid-valid flop,
// so there is no combinational path from out_ready to in_ready.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   flush                - drop both entries next cycle (wins over handshakes)
//   in_valid/in_ready    - upstream handshake; in_data/in_ctrl payload
//   out_valid/out_ready  - downstream handshake; out_data/out_ctrl payload
//   stall_cnt            - cycles with out_valid=1 and out_ready=0 (saturating)
// -----------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W   = PSR_DATA_W,
    parameter int CTRL_W   = PSR_CTRL_W,
    parameter int CNT_W    = PSR_CNT_W,
    parameter bit CLR_DATA = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              r_main_vld;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic              r_skid_vld;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;

    logic w_accept;
    logic w_main_free;

    assign w_accept    = in_valid & ~r_skid_vld;
    // main can take a new entry this edge: empty, or its entry leaves now
    assign w_main_free = ~r_main_vld | out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_vld  <= 1'b0;
            r_main_data <= '0;
            r_main_ctrl <= '0;
            r_skid_vld  <= 1'b0;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
        end else if (flush) begin
            r_main_vld  <= 1'b0;
            r_main_ctrl <= '0;
            r_skid_vld  <= 1'b0;
            if (CLR_DATA) r_main_data <= '0;
        end else if (w_main_free) begin
            if (r_skid_vld) begin
                // skid drains first to keep order; in_ready was 0 so no accept
                r_main_vld  <= 1'b1;
                r_main_data <= r_skid_data;
                r_main_ctrl <= r_skid_ctrl;
                r_skid_vld  <= 1'b0;
            end else if (w_accept) begin
                r_main_vld  <= 1'b1;
                r_main_data <= in_data;
                r_main_ctrl <= in_ctrl;
            end else begin
                // bubble: ctrl forced to 0 so no write enable leaks out
                r_main_vld  <= 1'b0;
                r_main_ctrl <= '0;
            end
        end else if (w_accept) begin
            r_skid_vld  <= 1'b1;
            r_skid_data <= in_data;
            r_skid_ctrl <= in_ctrl;
        end
    end

    assign in_ready  = ~r_skid_vld;
    assign out_valid = r_main_vld;
    assign out_data  = r_main_data;
    assign out_ctrl  = r_main_ctrl;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (r_main_vld & ~out_ready),
        .cnt (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Two instances share one stimulus stream: u_a with default parameters
// (CLR_DATA=1, CNT_W=16) and u_b with CLR_DATA=0, CNT_W=4.
module tb_pipe_stage_reg;
    import pipe_stage_reg_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_data;
    logic [23:0] in_ctrl;

    logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
    logic [31:0] a_out_data, b_out_data;
    logic [23:0] a_out_ctrl, b_out_ctrl;
    logic [15:0] a_stall;
    logic [3:0]  b_stall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg u_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .out_ctrl(a_out_ctrl), .stall_cnt(a_stall)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(24), .CNT_W(4), .CLR_DATA(1'b0)) u_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .out_ctrl(b_out_ctrl), .stall_cnt(b_stall)
    );

    // ---------------- reference model: FIFO of at most two entries ----------
    typedef struct packed {
        logic [31:0] d;
        logic [23:0] c;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] mdata_a, mdata_b;   // value held by the output data register
    logic [15:0] mcnt_a;
    logic [3:0]  mcnt_b;

    task automatic model_step();
        int sz;
        sz = mq.size();
        if (rst) begin
            mq.delete();
            mdata_a = '0; mdata_b = '0; mcnt_a = '0; mcnt_b = '0;
        end else begin
            if (sz > 0 && !out_ready) begin
                if (mcnt_a != 16'hFFFF) mcnt_a = mcnt_a + 16'd1;
                if (mcnt_b != 4'hF)     mcnt_b = mcnt_b + 4'd1;
            end
            if (flush) begin
                mq.delete();
                mdata_a = '0;           // CLR_DATA=1 zeroes, CLR_DATA=0 holds
            end else begin
                if (sz > 0 && out_ready) void'(mq.pop_front());
                if (in_valid && sz < 2) mq.push_back('{d: in_data, c: in_ctrl});
                if (mq.size() > 0) begin
                    mdata_a = mq[0].d;
                    mdata_b = mq[0].d;
                end
            end
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [23:0] ec;
        ec = (mq.size() > 0) ? mq[0].c : 24'h0;
        chk("a_valid", 64'(a_out_valid), 64'(mq.size() > 0));
        chk("a_ready", 64'(a_in_ready),  64'(mq.size() < 2));
        chk("a_ctrl",  64'(a_out_ctrl),  64'(ec));
        chk("a_data",  64'(a_out_data),  64'(mdata_a));
        chk("a_cnt",   64'(a_stall),     64'(mcnt_a));
        chk("b_valid", 64'(b_out_valid), 64'(mq.size() > 0));
        chk("b_ready", 64'(b_in_ready),  64'(mq.size() < 2));
        chk("b_ctrl",  64'(b_out_ctrl),  64'(ec));
        chk("b_data",  64'(b_out_data),  64'(mdata_b));
        chk("b_cnt",   64'(b_stall),     64'(mcnt_b));
    endtask

    task automatic step(input logic r, input logic f, input logic iv,
                        input logic [31:0] d, input logic [23:0] c, input logic ordy);
        rst = r; flush = f; in_valid = iv; in_data = d; in_ctrl = c; out_ready = ordy;
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    function automatic logic [23:0] mkctrl(input logic [31:0] d);
        logic [23:0] c;
        c = '0;
        c[PSR_ALUOP_LSB +: PSR_ALUOP_W] = d[3:0];
        c[PSR_REGWR_LSB +: PSR_REGWR_W] = 4'hF;
        c[PSR_MEMTOREG_BIT]             = d[4];
        return c;
    endfunction

    // ---------------- directed table ----------------------------------------
    typedef struct {
        logic        r, f, iv;
        logic [31:0] d;
        logic        ordy;
        logic        ev, erdy, cd;   // cd: compare out_data
        logic [31:0] ed;
        logic [15:0] ecnt;
    } vec_t;

    function automatic vec_t mkv(input logic r, input logic f, input logic iv,
                                 input logic [31:0] d, input logic ordy,
                                 input logic ev, input logic erdy, input logic cd,
                                 input logic [31:0] ed, input logic [15:0] ecnt);
        vec_t v;
        v.r = r; v.f = f; v.iv = iv; v.d = d; v.ordy = ordy;
        v.ev = ev; v.erdy = erdy; v.cd = cd; v.ed = ed; v.ecnt = ecnt;
        return v;
    endfunction

    vec_t vt[22];

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
        mdata_a = '0; mdata_b = '0; mcnt_a = '0; mcnt_b = '0;

        //           r  f  iv d         or  ev rdy cd ed        cnt
        vt[0]  = mkv(1, 0, 0, 32'h0,    0,  0, 1,  1, 32'h0,    0); // reset
        vt[1]  = mkv(0, 0, 1, 32'h11,   1,  1, 1,  1, 32'h11,   0); // streaming
        vt[2]  = mkv(0, 0, 1, 32'h22,   1,  1, 1,  1, 32'h22,   0);
        vt[3]  = mkv(0, 0, 1, 32'h33,   1,  1, 1,  1, 32'h33,   0);
        vt[4]  = mkv(0, 0, 0, 32'h0,    1,  0, 1,  0, 32'h0,    0);
        vt[5]  = mkv(0, 0, 1, 32'hA,    0,  1, 1,  1, 32'hA,    0); // backpressure
        vt[6]  = mkv(0, 0, 1, 32'hB,    0,  1, 0,  1, 32'hA,    1);
        vt[7]  = mkv(0, 0, 1, 32'hEE,   0,  1, 0,  1, 32'hA,    2);
        vt[8]  = mkv(0, 0, 0, 32'h0,    0,  1, 0,  1, 32'hA,    3);
        vt[9]  = mkv(0, 0, 0, 32'h0,    1,  1, 1,  1, 32'hB,    3);
        vt[10] = mkv(0, 0, 0, 32'h0,    1,  0, 1,  0, 32'h0,    3);
        vt[11] = mkv(0, 0, 1, 32'h1,    0,  1, 1,  1, 32'h1,    3); // flush, both full
        vt[12] = mkv(0, 0, 1, 32'h2,    0,  1, 0,  1, 32'h1,    4);
        vt[13] = mkv(0, 1, 1, 32'hC,    1,  0, 1,  1, 32'h0,    4);
        vt[14] = mkv(0, 0, 0, 32'h0,    0,  0, 1,  1, 32'h0,    4);
        vt[15] = mkv(0, 0, 1, 32'hDEAD, 0,  1, 1,  1, 32'hDEAD, 4);
        vt[16] = mkv(0, 1, 0, 32'h0,    1,  0, 1,  1, 32'h0,    4);
        vt[17] = mkv(0, 0, 1, 32'h7,    0,  1, 1,  1, 32'h7,    4); // reset mid-traffic
        vt[18] = mkv(0, 0, 1, 32'h8,    0,  1, 0,  1, 32'h7,    5);
        vt[19] = mkv(1, 1, 1, 32'h9,    0,  0, 1,  1, 32'h0,    0);
        vt[20] = mkv(0, 0, 1, 32'h5,    1,  1, 1,  1, 32'h5,    0);
        vt[21] = mkv(0, 0, 0, 32'h0,    1,  0, 1,  0, 32'h0,    0);

        for (int i = 0; i < 22; i++) begin
            step(vt[i].r, vt[i].f, vt[i].iv, vt[i].d, mkctrl(vt[i].d), vt[i].ordy);
            chk($sformatf("tbl%0d_valid", i), 64'(a_out_valid), 64'(vt[i].ev));
            chk($sformatf("tbl%0d_ready", i), 64'(a_in_ready),  64'(vt[i].erdy));
            chk($sformatf("tbl%0d_ctrl", i),  64'(a_out_ctrl),
                vt[i].ev ? 64'(mkctrl(vt[i].ed)) : 64'h0);
            chk($sformatf("tbl%0d_cnt", i),   64'(a_stall),     64'(vt[i].ecnt));
            if (vt[i].cd) chk($sformatf("tbl%0d_data", i), 64'(a_out_data), 64'(vt[i].ed));
            if (i == 16) chk("noclr_data_hold", 64'(b_out_data), 64'h0000DEAD);
        end

        // ---------------- saturation sequence -------------------------------
        step(1, 0, 0, 32'h0,  24'h0,         0);
        step(0, 0, 1, 32'h55, mkctrl(32'h55), 0);
        for (int k = 0; k < 20; k++) step(0, 0, 0, 32'h0, 24'h0, 0);
        chk("sat_b_15",   64'(b_stall), 64'd15);
        chk("nosat_a_20", 64'(a_stall), 64'd20);
        step(0, 1, 0, 32'h0, 24'h0, 1);
        chk("sat_b_flush", 64'(b_stall), 64'd15);
        chk("sat_flush_valid", 64'(b_out_valid), 64'd0);
        step(1, 0, 0, 32'h0, 24'h0, 0);
        chk("sat_b_rst", 64'(b_stall), 64'd0);

        // ---------------- randomized traffic vs model -----------------------
        for (int k = 0; k < 600; k++) begin
            step($urandom_range(63) == 0, $urandom_range(15) == 0,
                 $urandom_range(3) != 0, $urandom, 24'($urandom),
                 $urandom_range(2) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL take these parameters, one per line: name, default, meaning.
- DATA_W, 32, width of the datapath payload (PC, bus operands, instruction word).
- CTRL_W, 24, width of the packed control-signal vector.
- CNT_W, 16, width of the stall-cycle counter.
- CLR_DATA, 1: flush zeroes data; 0: flush clears valid and ctrl only.

REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock; all state updates on its rising edge.
- rst, in, 1, synchronous, active-high reset.
- flush, in, 1, synchronous bubble insertion, replacing the old per-register clr behaviour.
- in_valid, in, 1, upstream stage holds a valid entry.
- in_ready, out, 1, this stage can accept an entry; registered.
- in_data, in, DATA_W, upstream payload.
- in_ctrl, in, CTRL_W, upstream control vector.
- out_valid, out, 1, the head entry is valid.
- out_ready, in, 1, downstream consumes the head entry this cycle.
- out_data, out, DATA_W, head payload; registered.
- out_ctrl, out, CTRL_W, head control vector; registered.
- stall_cnt, out, CNT_W, count of cycles with out_valid=1 and out_ready=0.

Function
REQ-003 Storage SHALL be exactly two entries: a main register that drives the outputs and a skid register.
REQ-004 An input SHALL be accepted on a cycle with in_valid=1 and in_ready=1; an output SHALL be consumed on a cycle with out_valid=1 and out_ready=1.
REQ-005 in_ready SHALL equal NOT skid_valid, taken from a register, with no combinational path from out_ready.
REQ-006 An entry accepted into an empty stage SHALL appear on out_* on the next cycle, giving 1-cycle latency.
REQ-007 With out_ready held at 1, the stage SHALL sustain one accept and one consume per cycle with no bubbles.
REQ-008 If an input is accepted while main is valid and not consumed, the input SHALL go to skid; in_ready SHALL be 0 on the next cycle.
REQ-009 When main is consumed while skid is valid, skid SHALL move to main and skid SHALL clear; a simultaneous accept SHALL NOT occur, because in_ready=0.
REQ-010 When main is consumed while skid is empty, a simultaneous accept SHALL load main directly.
REQ-011 Entries SHALL leave in acceptance order, and out_data/out_ctrl SHALL stay stable while out_valid=1 and out_ready=0.
REQ-012 On flush=1, both entries SHALL be invalidated and out_ctrl SHALL be 0 on the next cycle.
REQ-013 On flush=1, out_data SHALL be 0 on the next cycle if CLR_DATA=1 and SHALL hold its value if CLR_DATA=0.
REQ-014 On flush=1, in_ready SHALL be 1 on the next cycle.
REQ-015 On flush=1, any input offered or consume granted in the same cycle SHALL be discarded; flush wins over every other event.
REQ-016 Whenever out_valid=0, out_ctrl SHALL be 0, so a bubble never asserts a write enable.
REQ-017 stall_cnt SHALL increment on each cycle with out_valid=1 and out_ready=0.
REQ-018 stall_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT be changed by flush.

Reset
REQ-019 While rst=1 at a clk edge, the next-cycle values SHALL be: out_valid=0, skid empty, in_ready=1, out_data=0, out_ctrl=0, stall_cnt=0.
REQ-020 rst SHALL override flush and all handshakes.
REQ-021 Entries in flight during reset SHALL be lost, and the first accept SHALL be possible on the cycle after rst falls.

Structure
REQ-022 Default widths and the control-vector field offsets (ALUop, RegWr byte enables, MemWr, MemtoReg, Branch, Jump, shift fields) SHALL live in the shared pipeline package.
REQ-023 Per-stage instances SHALL select fields from the package and SHALL NOT redefine them.
REQ-024 The stall counter SHALL be a sub-module sat_counter (parameter W; inputs clk, rst, inc; output cnt).

Verification
REQ-025 The bench SHALL cover these scenarios (DATA_W=32, CTRL_W=24):
- Streaming: out_ready=1, accept 0x11,0x22,0x33 on cycles 1-3 -> out_data 0x11,0x22,0x33 on cycles 2-4; stall_cnt=0.
- Backpressure: out_ready=0, accept 0xA then 0xB -> in_ready=0 from the next cycle; out_data stays 0xA; release out_ready -> 0xA then 0xB; stall_cnt equals the number of held cycles.
- Flush with CLR_DATA=1: both entries full, flush with in_valid=1, in_data=0xC -> next cycle out_valid=0, out_data=0, out_ctrl=0, in_ready=1, and 0xC is never output.
- Flush with CLR_DATA=0: main=0xDEAD -> out_data stays 0xDEAD, out_ctrl=0, out_valid=0.
- Saturation: CNT_W=4, 20 stalled cycles -> stall_cnt=15; flush -> stall_cnt still 15; rst -> stall_cnt=0.
- Reset mid-traffic: rst with both entries full and flush=1 -> reset values next cycle; accept 0x5 the cycle rst falls -> out_data=0x5 one cycle later.
